// File: rtl/parity_pkg.sv
// Shared types and constants for the parity frame receiver.
package parity_pkg;

  localparam int DEFAULT_DATA_W = 4;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity check: flags a mismatch between data, parity bit and mode.
module parity_calc
  import parity_pkg::*;
#(
  parameter int W = DEFAULT_DATA_W
) (
  input  logic [W-1:0] data_i,
  input  logic         par_i,
  input  logic         mode_i,
  output logic         mismatch_o
);

  // Odd mode expects an odd ones-count, so the expected XOR is inverted.
  assign mismatch_o = (^data_i) ^ par_i ^ (mode_i == PARITY_ODD);

endmodule

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: start marker, DATA_W data bits LSB-first, one parity bit.
// Optional macro PARITY_ERR_CNT_EN adds a saturating parity-error counter output.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              parity_mode,
  input  logic              sin_valid,
  input  logic              sin_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
`ifdef PARITY_ERR_CNT_EN
  output logic [CNT_W-1:0]  err_count,
`endif
  output logic              busy
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              vld_q, vld_d;
  logic              perr_q, perr_d;
  logic              ovr_q, ovr_d;
  logic              mismatch;
  logic              handshake;

  parity_calc #(.W(DATA_W)) u_calc (
    .data_i     (shift_q),
    .par_i      (sin_bit),
    .mode_i     (mode_q),
    .mismatch_o (mismatch)
  );

  assign handshake = (state_q == HOLD) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      mode_q  <= PARITY_EVEN;
      vld_q   <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      vld_q   <= vld_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    vld_d   = vld_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (sin_valid && sin_bit) begin
          mode_d  = parity_mode;
          shift_d = '0;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (sin_valid) begin
          shift_d[cnt_q] = sin_bit;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (sin_valid) begin
          perr_d  = mismatch;
          vld_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Bits arriving while the word is held are dropped; the handshake clear wins.
        if (sin_valid) ovr_d = 1'b1;
        if (out_ready) begin
          vld_d   = 1'b0;
          ovr_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (handshake && perr_q && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign data_out   = shift_q;
  assign parity_err = perr_q;
  assign out_valid  = vld_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule
